// File: rtl/module_keypad_pkg.sv
// Shared types and key map for the 4x4 keypad encoder.
// Imported by the encoder top and its synchronizer.
package module_keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Row/column position to the hex nibble the display path expects.
  function automatic logic [3:0] key_map(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // Lowest-index active-low row; only meaningful when some row is low.
  function automatic logic [1:0] first_low(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    if (!rows[2]) idx = 2'd2;
    if (!rows[1]) idx = 2'd1;
    if (!rows[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/module_keypad_encoder_sync2.sv
// Two-flop synchronizer for the keypad row pins.
// Resets to all ones, matching idle pulled-up rows.
module module_sync2
  import module_keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Two-stage capture of the asynchronous row pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/module_keypad_encoder.sv
// 4x4 keypad scanner with press/release debounce.
// Emits one hex nibble and a valid pulse per keystroke.
module module_keypad_encoder
  import module_keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_MAX =
    (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W =
    (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST =
    CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       col;
  logic [1:0]       lat_row;
  logic [3:0]       rs;
  logic [1:0]       col_nx;
  logic [3:0]       col_n_nx;
  logic             row_low;
  logic             any_low;

  module_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (rs)
  );

  assign col_nx   = col + 2'd1;
  assign col_n_nx = ~(4'b0001 << col_nx);
  assign row_low  = ~rs[lat_row];
  assign any_low  = ~&rs;

  // Scan/debounce FSM; column, code and flags are all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      cnt       <= '0;
      col       <= 2'd0;
      col_n     <= 4'b1110;
      lat_row   <= 2'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (any_low) begin
              lat_row <= first_low(rs);
              state   <= PRESS_DB;
            end else begin
              col   <= col_nx;
              col_n <= col_n_nx;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESS_DB: begin
          if (!row_low) begin
            state <= SCAN;
            cnt   <= '0;
            col   <= col_nx;
            col_n <= col_n_nx;
          end else if (cnt == DB_LAST) begin
            key_code  <= key_map(lat_row, col);
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!row_low) begin
            state <= REL_DB;
            cnt   <= '0;
          end
        end
        REL_DB: begin
          if (row_low) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state    <= SCAN;
            cnt      <= '0;
            key_held <= 1'b0;
            col      <= col_nx;
            col_n    <= col_n_nx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_module_keypad_encoder.sv
// Self-checking bench for module_keypad_encoder.
// Keypad matrix model plus an expected-code scoreboard queue.
module tb_module_keypad_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  module_keypad_encoder #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Physical matrix: a pressed key shorts its row to its driven column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (col_n[c] == 1'b0))
          row_n[r] = 1'b0;
  end

  task automatic do_reset();
    pressed = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drain one scoreboard entry when the DUT pulses key_valid.
  task automatic expect_pulse(input int budget, input string name,
                              output int lat);
    bit seen;
    logic [3:0] exp;
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= budget && !seen; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        seen = 1'b1;
        lat = i;
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: pulse with no expected entry, code=%h",
               name, key_code);
    end else begin
      exp = exp_q.pop_front();
      if (!seen) begin
        errors++;
        $display("FAIL %s: no key_valid in %0d cycles, expected code %h",
                 name, budget, exp);
      end else if (key_code !== exp) begin
        errors++;
        $display("FAIL %s: key_code=%h expected %h", name, key_code, exp);
      end
    end
  endtask

  task automatic no_pulse(input int n, input string name);
    int hits;
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (key_valid !== 1'b0) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL %s: %0d unexpected key_valid cycles, expected 0",
               name, hits);
    end
  endtask

  task automatic wait_release(input int budget, input string name);
    int pulses;
    pulses = 0;
    for (int i = 0; i < budget && key_held !== 1'b0; i++) begin
      @(negedge clk);
      if (key_valid !== 1'b0) pulses++;
    end
    checks++;
    if (key_held !== 1'b0 || pulses != 0) begin
      errors++;
      $display("FAIL %s: key_held=%b pulses=%0d expected held=0 pulses=0",
               name, key_held, pulses);
    end
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp;
    one = 4'b0001;
    do_reset();
    checks++;
    if (key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: code=%h valid=%b held=%b expected 0 0 0",
               key_code, key_valid, key_held);
    end
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      exp = ~(one << ((i / 4) % 4));
      checks++;
      if (col_n !== exp) begin
        errors++;
        $display("FAIL reset_scan cycle %0d: col_n=%b expected %b",
                 i, col_n, exp);
      end
    end
    no_pulse(8, "reset_idle");
  endtask

  task automatic test_clean_press();
    int lat;
    int bad;
    bit found;
    do_reset();
    pressed[6] = 1'b1;
    exp_q.push_back(4'h6);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (col_n === 4'b1011) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL press6_col2: col_n=%b expected 1011", col_n);
    end
    expect_pulse(20, "press6_code", lat);
    checks++;
    if (lat !== 12) begin
      errors++;
      $display("FAIL press6_latency: %0d cycles expected 12", lat);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (key_held !== 1'b1 || col_n !== 4'b1011 || key_valid !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL press6_hold: %0d bad cycles expected 0", bad);
    end
    pressed[6] = 1'b0;
    wait_release(30, "press6_release");
    checks++;
    if (col_n !== 4'b0111) begin
      errors++;
      $display("FAIL press6_resume: col_n=%b expected 0111", col_n);
    end
  endtask

  task automatic test_bounce();
    int lat;
    do_reset();
    pressed[0] = 1'b1;
    repeat (3) @(negedge clk);
    pressed[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (col_n !== 4'b1110) begin
      errors++;
      $display("FAIL bounce_frozen: col_n=%b expected 1110", col_n);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (col_n !== 4'b1101) begin
      errors++;
      $display("FAIL bounce_resume: col_n=%b expected 1101", col_n);
    end
    no_pulse(20, "bounce_press");
    do_reset();
    pressed[0] = 1'b1;
    exp_q.push_back(4'h1);
    expect_pulse(30, "bounce_key1", lat);
    pressed[0] = 1'b0;
    repeat (3) @(negedge clk);
    pressed[0] = 1'b1;
    no_pulse(30, "bounce_release");
    checks++;
    if (key_held !== 1'b1 || col_n !== 4'b1110) begin
      errors++;
      $display("FAIL bounce_still_held: held=%b col_n=%b expected 1 1110",
               key_held, col_n);
    end
    pressed[0] = 1'b0;
    wait_release(30, "bounce_final_release");
  endtask

  task automatic test_full_map();
    logic [3:0] codes[16];
    int lat;
    codes = '{4'h1, 4'h2, 4'h3, 4'hA,
              4'h4, 4'h5, 4'h6, 4'hB,
              4'h7, 4'h8, 4'h9, 4'hC,
              4'hE, 4'h0, 4'hF, 4'hD};
    do_reset();
    for (int k = 0; k < 16; k++) begin
      pressed = '0;
      pressed[k] = 1'b1;
      exp_q.push_back(codes[k]);
      expect_pulse(40, $sformatf("map_key%0d", k), lat);
      checks++;
      if (key_held !== 1'b1) begin
        errors++;
        $display("FAIL map_held%0d: key_held=%b expected 1", k, key_held);
      end
      pressed[k] = 1'b0;
      wait_release(40, $sformatf("map_release%0d", k));
    end
  endtask

  task automatic test_two_keys();
    int lat;
    do_reset();
    pressed[5]  = 1'b1;
    pressed[13] = 1'b1;
    exp_q.push_back(4'h5);
    expect_pulse(40, "two_keys_code", lat);
    pressed[3] = 1'b1;
    no_pulse(30, "two_keys_other_col");
    checks++;
    if (key_held !== 1'b1 || key_code !== 4'h5) begin
      errors++;
      $display("FAIL two_keys_hold: held=%b code=%h expected 1 5",
               key_held, key_code);
    end
    pressed = '0;
    wait_release(30, "two_keys_release");
    no_pulse(20, "two_keys_after");
  endtask

  task automatic test_reset_mid();
    int lat;
    for (int ph = 0; ph < 2; ph++) begin
      do_reset();
      pressed[0] = 1'b1;
      if (ph == 0) begin
        repeat (6) @(negedge clk);
      end else begin
        exp_q.push_back(4'h1);
        expect_pulse(30, "rst_held_key1", lat);
        repeat (2) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (col_n !== 4'b1110 || key_code !== 4'h0 ||
          key_valid !== 1'b0 || key_held !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid%0d: col=%b code=%h valid=%b held=%b expected 1110 0 0 0",
                 ph, col_n, key_code, key_valid, key_held);
      end
      pressed = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (col_n !== 4'b1110) begin
        errors++;
        $display("FAIL rst_mid%0d_col0: col_n=%b expected 1110", ph, col_n);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (col_n !== 4'b1101) begin
        errors++;
        $display("FAIL rst_mid%0d_col1: col_n=%b expected 1101", ph, col_n);
      end
      no_pulse(20, $sformatf("rst_mid%0d_quiet", ph));
    end
  endtask

  initial begin
    rst = 1'b1;
    pressed = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_full_map();
    test_two_keys();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
